// File: rtl/vfpu_job_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl_vfpu_package
// Description : Shared types and constants for the VFPU job sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package hwpe_ctrl_vfpu_package;

    typedef enum logic [2:0] {
        VFPU_JOB_IDLE  = 3'd0,
        VFPU_JOB_LOAD  = 3'd1,
        VFPU_JOB_RUN   = 3'd2,
        VFPU_JOB_DRAIN = 3'd3,
        VFPU_JOB_DONE  = 3'd4
    } vfpu_job_state_e;

    localparam logic VFPU_OP_ADD = 1'b0;
    localparam logic VFPU_OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vfpu_job_ctrl_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : vfpu_beat_counter
// Description : Counter that saturates at a terminal value and flags the
//               enabled increment that reaches it.
// Revision    : 1.0 - initial release
// ============================================================================
module vfpu_beat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] term_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 hit_o
);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_inc;
    logic                 w_at_term;

    assign w_at_term   = (r_count == term_i);
    assign w_count_inc = r_count + CNT_WIDTH'(1);
    // Hit fires only on the increment that lands on the terminal value.
    assign hit_o       = en_i && !w_at_term && (w_count_inc == term_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (en_i && !w_at_term) begin
            r_count <= w_count_inc;
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/vfpu_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vfpu_job_ctrl
// Description : Job sequencer for the VFPU add/sub streamer. Optional cycle
//               counter enabled by macro VFPU_JOB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vfpu_job_ctrl
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned NB_OPERANDS = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [CNT_WIDTH-1:0]   len_i,
    input  logic                   op_i,
    output logic                   op_o,
    output logic [NB_OPERANDS-1:0] src_start_o,
    output logic                   sink_start_o,
    input  logic                   res_valid_i,
    input  logic                   res_ready_i,
    input  logic                   sink_done_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_WIDTH-1:0]   beats_o,
    output logic [31:0]            cycles_o
);

    vfpu_job_state_e      r_state;
    vfpu_job_state_e      w_state_next;
    logic [CNT_WIDTH-1:0] r_len;
    logic                 r_op;
    logic                 w_idle;
    logic                 w_accept;
    logic                 w_zero_job;
    logic                 w_beat_en;
    logic                 w_beat_hit;

    assign w_idle     = (r_state == VFPU_JOB_IDLE);
    assign w_accept   = w_idle && start_i && (len_i != '0);
    assign w_zero_job = w_idle && start_i && (len_i == '0);
    assign w_beat_en  = (r_state == VFPU_JOB_RUN) && res_valid_i && res_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= VFPU_JOB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            VFPU_JOB_IDLE: begin
                if (w_accept) begin
                    w_state_next = VFPU_JOB_LOAD;
                end else if (w_zero_job) begin
                    w_state_next = VFPU_JOB_DONE;
                end
            end
            VFPU_JOB_LOAD:  w_state_next = VFPU_JOB_RUN;
            VFPU_JOB_RUN: begin
                // A sink flush coinciding with the final beat skips DRAIN.
                if (w_beat_hit) begin
                    w_state_next = sink_done_i ? VFPU_JOB_DONE : VFPU_JOB_DRAIN;
                end
            end
            VFPU_JOB_DRAIN: begin
                if (sink_done_i) begin
                    w_state_next = VFPU_JOB_DONE;
                end
            end
            VFPU_JOB_DONE:  w_state_next = VFPU_JOB_IDLE;
            default:        w_state_next = VFPU_JOB_IDLE;
        endcase
        if (clear_i) begin
            w_state_next = VFPU_JOB_IDLE;
        end
    end

    // Job parameters are only captured for non-empty jobs; op survives clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len <= '0;
            r_op  <= VFPU_OP_ADD;
        end else if (w_accept && !clear_i) begin
            r_len <= len_i;
            r_op  <= op_i;
        end
    end

    vfpu_beat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_beat_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i || w_accept),
        .en_i    (w_beat_en),
        .term_i  (r_len),
        .count_o (beats_o),
        .hit_o   (w_beat_hit)
    );

    assign op_o         = r_op;
    assign src_start_o  = {NB_OPERANDS{r_state == VFPU_JOB_LOAD}};
    assign sink_start_o = (r_state == VFPU_JOB_LOAD);
    assign busy_o       = !w_idle;
    assign done_o       = (r_state == VFPU_JOB_DONE);

`ifdef VFPU_JOB_PERF_CNT_EN
    logic [31:0] r_cycles;
    logic        w_cyc_active;
    logic        w_job_start;

    assign w_cyc_active = (r_state == VFPU_JOB_LOAD) || (r_state == VFPU_JOB_RUN) ||
                          (r_state == VFPU_JOB_DRAIN);
    assign w_job_start  = w_idle && start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cycles <= '0;
        end else if (clear_i || w_job_start) begin
            r_cycles <= '0;
        end else if (w_cyc_active && (r_cycles != '1)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign cycles_o = r_cycles;
`else
    assign cycles_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vfpu_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vfpu_job_ctrl
// Description : Self-checking bench for vfpu_job_ctrl with a job-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vfpu_job_ctrl;

    localparam int CNT_WIDTH   = 16;
    localparam int NB_OPERANDS = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b1;
    logic                   clear_i = 1'b0;
    logic                   start_i = 1'b0;
    logic [CNT_WIDTH-1:0]   len_i = '0;
    logic                   op_i = 1'b0;
    logic                   res_valid_i = 1'b0;
    logic                   res_ready_i = 1'b0;
    logic                   sink_done_i = 1'b0;
    logic                   op_o;
    logic [NB_OPERANDS-1:0] src_start_o;
    logic                   sink_start_o;
    logic                   busy_o;
    logic                   done_o;
    logic [CNT_WIDTH-1:0]   beats_o;
    logic [31:0]            cycles_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state carried between jobs.
    bit exp_op     = 1'b0;
    int exp_beats  = 0;
    int exp_cycles = 0;

    vfpu_job_ctrl #(
        .CNT_WIDTH   (CNT_WIDTH),
        .NB_OPERANDS (NB_OPERANDS)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .op_i         (op_i),
        .op_o         (op_o),
        .src_start_o  (src_start_o),
        .sink_start_o (sink_start_o),
        .res_valid_i  (res_valid_i),
        .res_ready_i  (res_ready_i),
        .sink_done_i  (sink_done_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .beats_o      (beats_o),
        .cycles_o     (cycles_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_outputs(input string tag, input bit busy, input bit done, input bit load);
        check_eq({tag, "_busy"},  32'(busy_o),       32'(busy));
        check_eq({tag, "_done"},  32'(done_o),       32'(done));
        check_eq({tag, "_src"},   32'(src_start_o),  load ? 32'((1 << NB_OPERANDS) - 1) : 32'd0);
        check_eq({tag, "_sink"},  32'(sink_start_o), 32'(load));
        check_eq({tag, "_beats"}, 32'(beats_o),      32'(exp_beats));
        check_eq({tag, "_op"},    32'(op_o),         32'(exp_op));
`ifdef VFPU_JOB_PERF_CNT_EN
        check_eq({tag, "_cycles"}, cycles_o, 32'(exp_cycles));
`else
        check_eq({tag, "_cycles"}, cycles_o, 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // hs_mode: 0 always handshake, 1 ready toggling, 2 random.
    // sd_delay: cycles from final beat to sink_done, or -1 for random pulses.
    task automatic run_job(input string tag, input int len, input bit op,
                           input int hs_mode, input int sd_delay, input bit stray);
        int c;
        int cnt;
        int last_c;
        int done_c;
        bit v, r, sd;
        start_i = 1'b1;
        len_i   = CNT_WIDTH'(len);
        op_i    = op;
        tick();
        start_i = 1'b0;
        op_i    = 1'($urandom);
        if (len != 0) begin
            exp_op    = op;
            exp_beats = 0;
        end
        exp_cycles = 0;
        cnt    = 0;
        last_c = -1;
        done_c = (len == 0) ? 1 : -1;
        c      = 1;
        forever begin
            check_outputs(tag, (done_c < 0) || (c <= done_c), c == done_c, (c == 1) && (len != 0));
            if (c == done_c) break;
            if (c > 400) begin
                check_eq({tag, "_timeout"}, 32'(c), 32'(done_c));
                break;
            end
            case (hs_mode)
                0:       begin v = 1'b1; r = 1'b1; end
                1:       begin v = 1'b1; r = c[0]; end
                default: begin v = 1'($urandom); r = 1'($urandom); end
            endcase
            if (c >= 2 && cnt < len && v && r) begin
                cnt++;
                if (cnt == len) last_c = c;
            end
            if (sd_delay < 0) sd = ($urandom_range(0, 2) == 0);
            else              sd = (last_c >= 0) && (c == last_c + sd_delay);
            if (last_c >= 0 && sd && done_c < 0) done_c = c + 1;
            res_valid_i = v;
            res_ready_i = r;
            sink_done_i = sd;
            start_i     = stray && (c == 2 || $urandom_range(0, 3) == 0);
            len_i       = CNT_WIDTH'(7);
            tick();
            start_i    = 1'b0;
            exp_cycles = exp_cycles + 1;
            exp_beats  = (len != 0) ? cnt : exp_beats;
            c++;
        end
        res_valid_i = 1'b0;
        res_ready_i = 1'b0;
        sink_done_i = 1'b0;
        tick();
        check_outputs({tag, "_after"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        #2;
        check_outputs("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check_outputs("idle", 1'b0, 1'b0, 1'b0);

        run_job("add4", 4, 1'b0, 0, 2, 1'b0);
        run_job("sub3", 3, 1'b1, 1, -1, 1'b0);
        run_job("zero", 0, 1'b0, 0, 0, 1'b0);
        run_job("busy_start", 2, 1'b0, 0, 1, 1'b1);
        run_job("perf2", 2, 1'b1, 0, 1, 1'b0);

        // Clear mid-job after two of five beats.
        start_i = 1'b1; len_i = CNT_WIDTH'(5); op_i = 1'b0;
        tick();
        start_i = 1'b0;
        exp_op = 1'b0; exp_beats = 0; exp_cycles = 0;
        check_outputs("clr_load", 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            res_valid_i = 1'b1; res_ready_i = 1'b1;
            tick();
            exp_cycles++;
            if (i >= 2) exp_beats++;
        end
        check_outputs("clr_run", 1'b1, 1'b0, 1'b0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        exp_beats = 0; exp_cycles = 0;
        check_outputs("clr_idle", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            res_valid_i = 1'($urandom); res_ready_i = 1'($urandom);
            sink_done_i = 1'($urandom);
            tick();
            check_outputs("clr_quiet", 1'b0, 1'b0, 1'b0);
        end
        res_valid_i = 1'b0; res_ready_i = 1'b0; sink_done_i = 1'b0;

        // Reset while waiting in DRAIN.
        start_i = 1'b1; len_i = CNT_WIDTH'(1); op_i = 1'b1;
        tick();
        start_i = 1'b0;
        exp_op = 1'b1; exp_beats = 0; exp_cycles = 0;
        check_outputs("rst_load", 1'b1, 1'b0, 1'b1);
        tick();
        exp_cycles = 1;
        check_outputs("rst_run", 1'b1, 1'b0, 1'b0);
        res_valid_i = 1'b1; res_ready_i = 1'b1;
        tick();
        res_valid_i = 1'b0; res_ready_i = 1'b0;
        exp_beats = 1; exp_cycles = 2;
        check_outputs("rst_drain", 1'b1, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        exp_op = 1'b0; exp_beats = 0; exp_cycles = 0;
        check_outputs("rst_async", 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        sink_done_i = 1'b1;
        tick();
        sink_done_i = 1'b0;
        check_outputs("rst_idle", 1'b0, 1'b0, 1'b0);

        for (int j = 0; j < 40; j++) begin
            run_job("rnd", int'($urandom_range(0, 9)), 1'($urandom), 2, -1, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
